// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: register-usage info from ID/EX/MEM in, fetch/pipe control and perf counters out
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic id_use_rs1, id_use_rs2, id_is_branch, id_br_taken;
  logic ex_regwrite, ex_memread, mem_memread, ex_redirect, dmem_wait, cnt_clear;
  logic keep, nop, branch_pc_early_ctrl, branch_pc_ctrl, id_ex_bubble, pipe_freeze, stalled;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_br_taken,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread, ex_redirect, dmem_wait, cnt_clear,
    input  keep, nop, branch_pc_early_ctrl, branch_pc_ctrl, id_ex_bubble, pipe_freeze, stalled,
           stall_cycles, flush_count
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_br_taken,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread, ex_redirect, dmem_wait, cnt_clear,
    output keep, nop, branch_pc_early_ctrl, branch_pc_ctrl, id_ex_bubble, pipe_freeze, stalled,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/redirect controller with stall FSM and saturating perf counters
module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int BR_LOAD_STALL = 2
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave h
);
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [1:0] BLS = 2'(BR_LOAD_STALL);
  state_t state;
  logic [1:0] cnt, n;
  logic [CNT_W-1:0] sc, fc;
  logic ex_hit, mem_hit, stall, live;
  assign ex_hit = (h.id_use_rs1 && h.id_rs1 != 5'd0 && h.id_rs1 == h.ex_rd) ||
                  (h.id_use_rs2 && h.id_rs2 != 5'd0 && h.id_rs2 == h.ex_rd);
  assign mem_hit = (h.id_use_rs1 && h.id_rs1 != 5'd0 && h.id_rs1 == h.mem_rd) ||
                   (h.id_use_rs2 && h.id_rs2 != 5'd0 && h.id_rs2 == h.mem_rd);
  // BLS >= 1, so a branch on a load result already covers the plain load-use rule
  assign n = (ex_hit && h.ex_memread) ? (h.id_is_branch ? BLS : 2'd1) :
             (h.id_is_branch && ((ex_hit && h.ex_regwrite) || (mem_hit && h.mem_memread))) ? 2'd1 : 2'd0;
  assign stall = state == STALL || n != 2'd0;
  assign live = !h.dmem_wait;
  assign h.pipe_freeze = h.dmem_wait;
  assign h.keep = h.dmem_wait || (!h.ex_redirect && stall);
  assign h.branch_pc_ctrl = live && h.ex_redirect;
  assign h.id_ex_bubble = live && (h.ex_redirect || stall);
  assign h.branch_pc_early_ctrl = live && !h.ex_redirect && !stall && h.id_is_branch && h.id_br_taken;
  assign h.nop = h.branch_pc_ctrl || h.branch_pc_early_ctrl;
  assign h.stalled = state == STALL;
  assign h.stall_cycles = sc;
  assign h.flush_count = fc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      cnt <= 2'd0;
      sc <= '0;
      fc <= '0;
    end else begin
      if (live) begin
        if (h.ex_redirect) begin
          state <= RUN;
          cnt <= 2'd0;
        end else if (state == STALL) begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= RUN;
        end else if (n > 2'd1) begin
          state <= STALL;
          cnt <= n - 2'd1;
        end
      end
      sc <= h.cnt_clear ? '0 : (live && !h.ex_redirect && stall && !(&sc)) ? sc + CNT_W'(1) : sc;
      fc <= h.cnt_clear ? '0 : (live && h.ex_redirect && !(&fc)) ? fc + CNT_W'(1) : fc;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, corner sequences and random run against a remaining-stall model
module tb_hazard_ctrl;
  localparam int CNT_W = 8;
  localparam int BLS = 2;
  localparam int MAX = (1 << CNT_W) - 1;
  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic u1, u2, br, tk;
    logic [4:0] exrd;
    logic exw, exm;
    logic [4:0] memrd;
    logic memm, redir, dw, clr;
  } vin_t;
  typedef struct {
    vin_t i;
    logic [5:0] ctl;
    logic st;
  } vec_t;
  logic clk = 0, rst = 0;
  int total = 0, passed = 0;
  int rem = 0, sc = 0, fc = 0;
  vec_t tab[$];
  hazard_ctrl_if #(.CNT_W(CNT_W)) h();
  hazard_ctrl #(.CNT_W(CNT_W), .BR_LOAD_STALL(BLS)) dut (.clk(clk), .rst(rst), .h(h));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout want $finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask
  function automatic logic [5:0] ctl_now();
    return {h.keep, h.nop, h.branch_pc_early_ctrl, h.branch_pc_ctrl, h.id_ex_bubble, h.pipe_freeze};
  endfunction
  task automatic drv(input vin_t v);
    h.id_rs1 = v.rs1; h.id_rs2 = v.rs2; h.id_use_rs1 = v.u1; h.id_use_rs2 = v.u2;
    h.id_is_branch = v.br; h.id_br_taken = v.tk; h.ex_rd = v.exrd; h.ex_regwrite = v.exw;
    h.ex_memread = v.exm; h.mem_rd = v.memrd; h.mem_memread = v.memm; h.ex_redirect = v.redir;
    h.dmem_wait = v.dw; h.cnt_clear = v.clr;
  endtask
  function automatic int mx(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int need(input vin_t v);
    bit e = (v.u1 && v.rs1 != 0 && v.rs1 == v.exrd) || (v.u2 && v.rs2 != 0 && v.rs2 == v.exrd);
    bit m = (v.u1 && v.rs1 != 0 && v.rs1 == v.memrd) || (v.u2 && v.rs2 != 0 && v.rs2 == v.memrd);
    int k = 0;
    if (e && v.exm) k = mx(k, 1);
    if (v.br && e && v.exw && !v.exm) k = mx(k, 1);
    if (v.br && e && v.exm) k = mx(k, BLS);
    if (v.br && m && v.memm) k = mx(k, 1);
    return k;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("rst_stalled", 32'(h.stalled), 0);
    chk("rst_stall_cycles", 32'(h.stall_cycles), 0);
    chk("rst_flush_count", 32'(h.flush_count), 0);
    drv('0);
    rem = 0; sc = 0; fc = 0;
    #1 rst = 1;
    @(negedge clk);
  endtask
  task automatic step(input vin_t v);
    int k;
    bit s, e;
    logic [5:0] want;
    drv(v);
    #1;
    k = need(v);
    s = rem > 0 || k > 0;
    e = v.br && v.tk;
    want = v.dw ? 6'b100001 : v.redir ? 6'b010110 : s ? 6'b100010 : {1'b0, e, e, 3'b000};
    chk("ctl", 32'(ctl_now()), 32'(want));
    if (!v.dw) begin
      if (v.redir) begin
        rem = 0;
        fc = fc < MAX ? fc + 1 : fc;
      end else if (s) begin
        sc = sc < MAX ? sc + 1 : sc;
        rem = rem > 0 ? rem - 1 : k - 1;
      end
    end
    if (v.clr) begin sc = 0; fc = 0; end
    @(posedge clk);
    #1;
    chk("stalled", 32'(h.stalled), 32'(rem > 0));
    chk("stall_cycles", 32'(h.stall_cycles), 32'(sc));
    chk("flush_count", 32'(h.flush_count), 32'(fc));
    @(negedge clk);
  endtask
  task automatic add(input vin_t i, input logic [5:0] c, input logic st);
    vec_t t;
    t.i = i; t.ctl = c; t.st = st;
    tab.push_back(t);
  endtask
  initial begin
    vin_t lu, bl, tb_, v;
    lu = '{rs1:5'd5, u1:1'b1, exrd:5'd5, exm:1'b1, default:'0};
    bl = '{rs2:5'd7, u2:1'b1, br:1'b1, exrd:5'd7, exm:1'b1, default:'0};
    tb_ = '{rs1:5'd3, u1:1'b1, br:1'b1, tk:1'b1, exrd:5'd4, exw:1'b1, default:'0};
    // {keep, nop, early, redirect, bubble, freeze}, stalled after the edge
    add('0, 6'b000000, 0);
    add(lu, 6'b100010, 0);
    add('{u1:1'b1, exm:1'b1, default:'0}, 6'b000000, 0);
    add('{rs1:5'd5, exrd:5'd5, exm:1'b1, default:'0}, 6'b000000, 0);
    add(bl, 6'b100010, 1);
    add('{rs1:5'd9, u1:1'b1, br:1'b1, exrd:5'd9, exw:1'b1, default:'0}, 6'b100010, 0);
    add('{rs2:5'd2, u2:1'b1, br:1'b1, memrd:5'd2, memm:1'b1, default:'0}, 6'b100010, 0);
    add(tb_, 6'b011000, 0);
    add('{br:1'b1, tk:1'b1, redir:1'b1, default:'0}, 6'b010110, 0);
    add('{rs1:5'd5, u1:1'b1, exrd:5'd5, exm:1'b1, dw:1'b1, default:'0}, 6'b100001, 0);
    add('{rs1:5'd6, u1:1'b1, br:1'b1, tk:1'b1, memrd:5'd6, default:'0}, 6'b011000, 0);
    add('{rs1:5'd8, u1:1'b1, exrd:5'd8, exw:1'b1, default:'0}, 6'b000000, 0);
    drv('0);
    #12 rst = 1;
    foreach (tab[k]) begin
      do_reset();
      drv(tab[k].i);
      #1 chk($sformatf("vec%0d_ctl", k), 32'(ctl_now()), 32'(tab[k].ctl));
      @(posedge clk);
      #1 chk($sformatf("vec%0d_stalled", k), 32'(h.stalled), 32'(tab[k].st));
      @(negedge clk);
    end
    do_reset();
    step(lu);
    chk("lu_count", 32'(h.stall_cycles), 1);
    step('0);
    do_reset();
    step(bl);
    chk("bl_stalled2", 32'(h.stalled), 1);
    step(bl);
    chk("bl_released", 32'(h.stalled), 0);
    step(tb_);
    chk("bl_count", 32'(h.stall_cycles), 2);
    do_reset();
    step(bl);
    v = bl; v.redir = 1;
    step(v);
    chk("redir_run", 32'(h.stalled), 0);
    chk("redir_flush", 32'(h.flush_count), 1);
    do_reset();
    step(bl);
    v = bl; v.dw = 1;
    repeat (3) step(v);
    chk("dw_hold_state", 32'(h.stalled), 1);
    chk("dw_hold_count", 32'(h.stall_cycles), 1);
    step(bl);
    chk("dw_done", 32'(h.stalled), 0);
    chk("dw_total", 32'(h.stall_cycles), 2);
    do_reset();
    repeat ((1 << CNT_W) + 5) step(lu);
    chk("sat", 32'(h.stall_cycles), 32'(MAX));
    step(bl);
    do_reset();
    step('0);
    for (int c = 0; c < 400; c++) begin
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom_range(0, 1)); v.u2 = 1'($urandom_range(0, 1));
      v.br = 1'($urandom_range(0, 1)); v.tk = 1'($urandom_range(0, 1));
      v.exrd = 5'($urandom_range(0, 3)); v.exw = 1'($urandom_range(0, 1));
      v.exm = 1'($urandom_range(0, 1)); v.memrd = 5'($urandom_range(0, 3));
      v.memm = 1'($urandom_range(0, 1)); v.redir = $urandom_range(0, 9) == 0;
      v.dw = $urandom_range(0, 7) == 0; v.clr = $urandom_range(0, 49) == 0;
      step(v);
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and redirect controller for the 5-stage core.
- Drives the fetch stage's hold (keep), bubble-injection (nop) and branch-redirect selects from ID/EX/MEM register-usage info and data-memory wait.
- Sequences multi-cycle stalls with a small FSM and stall counter, squashes ID/EX on stall or flush, and keeps saturating performance counters.

Parameters:
- CNT_W, 16, width of the performance counters stall_cycles and flush_count.
- BR_LOAD_STALL, 2, stall cycles when an ID-stage branch reads the rd of a load currently in EX (range 1..3).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- id_rs1  input  5  source register 1 of the instruction in ID
- id_rs2  input  5  source register 2 of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_is_branch  input  1  ID instruction is an early-resolved branch or jump
- id_br_taken  input  1  early branch resolved taken in ID
- ex_rd  input  5  destination register of the instruction in EX
- ex_regwrite  input  1  EX instruction writes ex_rd
- ex_memread  input  1  EX instruction is a load
- mem_rd  input  5  destination register of the instruction in MEM
- mem_memread  input  1  MEM instruction is a load
- ex_redirect  input  1  EX-stage branch mispredict or redirect
- dmem_wait  input  1  data memory not ready; whole pipe must freeze
- cnt_clear  input  1  synchronous clear of the performance counters
- keep  output  1  fetch holds PC and instruction registers
- nop  output  1  fetch injects a NOP into IF/ID
- branch_pc_early_ctrl  output  1  fetch selects the early branch target
- branch_pc_ctrl  output  1  fetch selects the EX redirect target
- id_ex_bubble  output  1  ID/EX latches a bubble instead of the ID instruction
- pipe_freeze  output  1  all pipeline registers hold
- stalled  output  1  FSM is in STALL
- stall_cycles  output  CNT_W  saturating count of stall cycles
- flush_count  output  CNT_W  saturating count of EX redirects

Behaviour:
- Control outputs (keep, nop, branch_*, id_ex_bubble, pipe_freeze) are combinational (Mealy) from the current state, the counter and the inputs. Fetch samples them at the same posedge. State, counter and performance counters are registered.
- Reset (rst=0, async) sets state=RUN, cnt=0, stall_cycles=0, flush_count=0. With all inputs 0, every control output is 0.
- Hazard matching: a register match requires a nonzero register and the corresponding id_use_rsX=1. A match against register x0 is never a hazard.
- Stall need n, computed in RUN as the maximum of the following rules:
  - Load-use: EX is a load and matches ID rs1 or rs2 -> n=1.
  - ID branch with EX match, ex_regwrite=1 and ex_memread=0 -> n=1.
  - ID branch with EX match and ex_memread=1 -> n=BR_LOAD_STALL.
  - ID branch with MEM match and mem_memread=1 -> n=1.
- Priority per cycle, highest first:
  1. dmem_wait: pipe_freeze=1 and keep=1; all other controls 0. State, cnt and flush_count hold. stall_cycles is not incremented.
  2. ex_redirect: branch_pc_ctrl=1, nop=1, id_ex_bubble=1, early redirect suppressed. Next state=RUN, cnt=0. flush_count increments.
  3. Stall (RUN with n>0, or in STALL): keep=1, id_ex_bubble=1, nop=0, branch_pc_early_ctrl=0. stall_cycles increments.
     - From RUN: if n=1 stay in RUN; else go to STALL with cnt=n-1.
     - In STALL: cnt decrements; when cnt==1 the next state is RUN.
  4. Otherwise: branch_pc_early_ctrl = id_is_branch & id_br_taken. When it is 1, nop=1 as well (squashes the wrong-path fetch).
- STALL does not re-evaluate hazards; the stall length is fixed on entry. On return to RUN, hazards are evaluated fresh.
- Counters saturate at all-ones and do not wrap. cnt_clear zeroes both counters and takes priority over increment.
- Reset asserted mid-stall returns to RUN immediately, with no residual stall.
- stalled = (state==STALL).

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> keep=1 and id_ex_bubble=1 for exactly 1 cycle; stall_cycles=1.
- Branch after load: id_is_branch=1, id_rs2=7, ex_memread=1, ex_rd=7, BR_LOAD_STALL=2 -> keep high 2 cycles, stalled=1 on the second; then branch_pc_early_ctrl=1 and nop=1 when id_br_taken=1.
- x0 immunity: ex_rd=0, ex_memread=1, id_rs1=0 -> no stall; all controls 0.
- Redirect during STALL: enter STALL (cnt=1), assert ex_redirect -> branch_pc_ctrl=1, nop=1, next state RUN, flush_count=1.
- dmem_wait for 3 cycles mid-STALL -> pipe_freeze=1 for 3 cycles, cnt unchanged, stall completes afterward with the same remaining length.
- Saturation and reset: force 2^CNT_W+5 stall cycles -> stall_cycles=all-ones; async rst low mid-stall -> state RUN, counters 0.
